// File: rtl/fifo_stream_reader.sv
// Read-side adapter: drains a req/empty FIFO port with one-cycle read latency
// and re-presents the words as a valid/ready stream through a 2-entry buffer.
module fifo_stream_reader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             fifo_read_req,
   input  logic [WIDTH-1:0] fifo_read_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [CNT_W-1:0] word_count
);

   // Stream handshake: a word transfers on any rising edge where m_valid and
   // m_ready are both high; m_valid/m_data never depend on m_ready and the
   // presented word is held unchanged until it transfers.

   logic [WIDTH-1:0] mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic             inflight;
   logic [1:0]       occ;
   logic             pop;
   logic [2:0]       demand;

   assign pop    = m_valid & m_ready;
   assign demand = {1'b0, occ} + {2'b00, inflight};

   // A slot freed by this cycle's pop may be claimed by a new request, so a
   // full buffer that is draining still keeps the read port busy.
   assign fifo_read_req = !rst && !fifo_empty && (demand < (3'd2 + {2'b00, pop}));

   assign m_valid = (occ != 2'd0);
   assign m_data  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0]     <= '0;
         mem[1]     <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         inflight   <= 1'b0;
         occ        <= 2'd0;
         word_count <= '0;
      end else begin
         inflight <= fifo_read_req;
         // Returning data always has a reserved slot, so capture is unconditional.
         if (inflight) begin
            mem[wr_ptr] <= fifo_read_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr     <= ~rd_ptr;
            word_count <= word_count + CNT_W'(1);
         end
         case ({inflight, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: the bench plays the FIFO, keeps a queue-based
// model of the buffer and a write-order scoreboard, and checks every cycle.
module tb_fifo_stream_reader;

   logic       clk;
   logic       rst;
   logic       fifo_empty;
   logic       fifo_read_req;
   logic [7:0] fifo_read_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [15:0] word_count;
   logic       req4;
   logic       valid4;
   logic [7:0] data4;
   logic [3:0] wc4;

   fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read_req(fifo_read_req),
      .fifo_read_data(fifo_read_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .word_count(word_count)
   );

   fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read_req(req4),
      .fifo_read_data(fifo_read_data), .m_valid(valid4), .m_ready(m_ready),
      .m_data(data4), .word_count(wc4)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO contents, behavioural buffer model, scoreboard
   logic [7:0] fifo_q[$];
   logic [7:0] buf_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         got_cyc[$];
   bit         inflight_m;
   logic [7:0] inflight_w;
   int         cnt_m;
   int         cyc;
   int         req_cnt;
   int         req_first;
   int         checks;
   int         passes;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic add_word(input logic [7:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic clear_model();
      fifo_q.delete();
      buf_q.delete();
      exp_q.delete();
      inflight_m = 1'b0;
      cnt_m      = 0;
   endtask

   // One clock cycle: check outputs mid-cycle, advance the model, act as FIFO.
   task automatic cycle();
      logic [7:0] nxt;
      bit pop_m;
      bit req_m;
      nxt = 8'($urandom);
      fifo_empty = (fifo_q.size() == 0);
      #4;
      if (rst) begin
         chk("rst_req", fifo_read_req, 0);
         chk("rst_valid", m_valid, 0);
         chk("rst_data", m_data, 0);
         chk("rst_count", word_count, 0);
         clear_model();
      end else begin
         pop_m = (buf_q.size() != 0) && m_ready;
         req_m = (fifo_q.size() != 0) && ((buf_q.size() + int'(inflight_m) - int'(pop_m)) < 2);
         chk("req", fifo_read_req, req_m);
         chk("req4", req4, req_m);
         chk("valid", m_valid, buf_q.size() != 0);
         chk("valid4", valid4, buf_q.size() != 0);
         if (buf_q.size() != 0) begin
            chk("data", m_data, buf_q[0]);
            chk("data4", data4, buf_q[0]);
         end
         chk("count", word_count, cnt_m[15:0]);
         chk("count4", wc4, cnt_m[3:0]);
         if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            got_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("order_extra", 1, 0);
            else chk("order", m_data, exp_q.pop_front());
         end
         if (fifo_read_req) begin
            req_cnt++;
            if (req_first < 0) req_first = cyc;
         end
         if (pop_m) begin
            void'(buf_q.pop_front());
            cnt_m++;
         end
         if (inflight_m) buf_q.push_back(inflight_w);
         inflight_m = req_m;
         if (req_m) inflight_w = fifo_q[0];
         if (fifo_read_req && fifo_q.size() != 0) nxt = fifo_q.pop_front();
      end
      @(posedge clk);
      #1;
      cyc++;
      fifo_read_data = nxt;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic reset_log();
      got_q.delete();
      got_cyc.delete();
      req_cnt   = 0;
      req_first = -1;
   endtask

   initial begin
      checks = 0; passes = 0; cyc = 0;
      rst = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_read_data = 8'h00;
      clear_model();
      reset_log();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_req", fifo_read_req, 0);
      chk("reset_valid", m_valid, 0);
      chk("reset_data", m_data, 0);
      chk("reset_count", word_count, 0);
      rst = 1'b0;

      // streaming 0x01..0x10 with m_ready held high
      reset_log();
      m_ready = 1'b1;
      for (int i = 1; i <= 16; i++) add_word(8'(i));
      run(20);
      chk("t2_n", got_q.size(), 16);
      for (int i = 0; i < 16 && i < got_q.size(); i++) chk("t2_word", got_q[i], i + 1);
      if (got_cyc.size() == 16) begin
         chk("t2_no_bubble", got_cyc[15] - got_cyc[0], 15);
         chk("t2_latency", got_cyc[0] - req_first, 2);
      end
      chk("t2_count", word_count, 16);
      add_word(8'h11);
      run(4);
      chk("t6_count16", word_count, 17);
      chk("t6_count4_wrap", wc4, 1);

      // back-pressure: 4 words, downstream stalled for 10 cycles
      reset_log();
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) add_word(8'(i));
      run(10);
      chk("t3_reqs", req_cnt, 2);
      chk("t3_hold_valid", m_valid, 1);
      chk("t3_hold_data", m_data, 8'h01);
      m_ready = 1'b1;
      run(8);
      chk("t3_n", got_q.size(), 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t3_word", got_q[i], i + 1);

      // alternating m_ready over 32 words
      reset_log();
      for (int i = 0; i < 32; i++) add_word(8'(8'h40 + i));
      for (int i = 0; i < 80; i++) begin
         m_ready = (i % 2 == 0);
         cycle();
      end
      m_ready = 1'b1;
      run(4);
      chk("t4_n", got_q.size(), 32);
      for (int i = 0; i < 32 && i < got_q.size(); i++) chk("t4_word", got_q[i], 8'h40 + i);

      // single word: FIFO goes empty while its data is still returning
      reset_log();
      add_word(8'hA5);
      run(6);
      chk("t5_reqs", req_cnt, 1);
      chk("t5_n", got_q.size(), 1);
      if (got_q.size() != 0) chk("t5_word", got_q[0], 8'hA5);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (fifo_q.size() < 6) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) add_word(8'($urandom));
         end
         m_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      m_ready = 1'b1;
      run(16);
      chk("rand_drained", exp_q.size(), 0);

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < 8; i++) add_word(8'($urandom));
      run(3);
      #2;
      rst = 1'b1;
      #1;
      chk("t1_req", fifo_read_req, 0);
      chk("t1_valid", m_valid, 0);
      chk("t1_data", m_data, 0);
      chk("t1_count", word_count, 0);
      chk("t1_count4", wc4, 0);
      clear_model();
      run(2);
      rst = 1'b0;
      reset_log();
      for (int i = 0; i < 5; i++) add_word(8'(8'hC0 + i));
      run(10);
      chk("t1_after_n", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) chk("t1_after_word", got_q[i], 8'hC0 + i);
      chk("t1_after_count", word_count, 5);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
